revelar_celdas: RTL and testbench



---
 rtl/revelar_celdas.sv | 145 ++++++++++++++
 tb/tb_revelar_celdas.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/revelar_celdas.sv
// Cell-reveal engine for an 8x8 minesweeper board: reveals the selected cell
// and flood-fills zero-count regions through an internal LIFO of cell indices.
module revelar_celdas (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [2:0]   pos_x,
  input  logic [2:0]   pos_y,
  input  logic [63:0]  bomb_map,
  input  logic [255:0] num_map,
  input  logic [5:0]   numero_bombas,
  output logic [63:0]  revealed,
  output logic         busy,
  output logic         done,
  output logic         game_over,
  output logic         win
);

  typedef enum logic [2:0] {IDLE, CHECK, POP, SCAN, FINISH, LOST, WON} state_t;

  state_t      state, state_n;
  logic [5:0]  stack [64];
  logic [6:0]  sp;
  logic [63:0] queued;
  logic [6:0]  rev_cnt;
  logic [5:0]  nb;
  logic [2:0]  dir;
  logic [5:0]  cur;
  logic [5:0]  idx;

  logic [5:0]  top;
  logic [3:0]  top_cnt;
  logic [3:0]  nx, ny;
  logic [5:0]  nbr;
  logic        nbr_ok;
  logic        push, pop;
  logic [5:0]  push_val;
  logic        win_hit;

  assign top     = stack[sp[5:0] - 6'd1];
  assign top_cnt = num_map[{top, 2'b00} +: 4];
  assign win_hit = (rev_cnt + {1'b0, nb}) == 7'd64;
  assign busy    = (state == CHECK) || (state == POP) ||
                   (state == SCAN)  || (state == FINISH);

  // Neighbour coordinates in 4 bits: stepping off either edge (-1 -> 15, 8)
  // always sets bit 3, which doubles as the out-of-bounds flag.
  always_comb begin
    nx = {1'b0, cur[2:0]};
    ny = {1'b0, cur[5:3]};
    unique case (dir)
      3'd0: begin nx = nx - 4'd1; ny = ny - 4'd1; end
      3'd1: begin                 ny = ny - 4'd1; end
      3'd2: begin nx = nx + 4'd1; ny = ny - 4'd1; end
      3'd3: begin nx = nx - 4'd1;                 end
      3'd4: begin nx = nx + 4'd1;                 end
      3'd5: begin nx = nx - 4'd1; ny = ny + 4'd1; end
      3'd6: begin                 ny = ny + 4'd1; end
      default: begin nx = nx + 4'd1; ny = ny + 4'd1; end
    endcase
    nbr    = {ny[2:0], nx[2:0]};
    nbr_ok = !(nx[3] || ny[3]) && !revealed[nbr] && !queued[nbr] && !bomb_map[nbr];
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    push_val = idx;
    pop      = 1'b0;
    unique case (state)
      IDLE:   if (sel) state_n = CHECK;
      CHECK: begin
        if (revealed[idx])      state_n = IDLE;
        else if (bomb_map[idx]) state_n = LOST;
        else begin
          push    = 1'b1;
          state_n = POP;
        end
      end
      POP: begin
        pop = 1'b1;
        if (top_cnt == 4'd0)   state_n = SCAN;
        else if (sp == 7'd1)   state_n = FINISH;
      end
      SCAN: begin
        if (nbr_ok) begin
          push     = 1'b1;
          push_val = nbr;
        end
        if (dir == 3'd7) state_n = (sp == 7'd0 && !nbr_ok) ? FINISH : POP;
      end
      FINISH: state_n = win_hit ? WON : IDLE;
      LOST:   state_n = LOST;
      WON:    state_n = WON;
      default: state_n = IDLE;
    endcase
  end

  // Stack storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack[sp[5:0]] <= push_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= '0;
      queued    <= '0;
      rev_cnt   <= '0;
      nb        <= '0;
      dir       <= '0;
      cur       <= '0;
      idx       <= '0;
      revealed  <= '0;
      done      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      state <= state_n;
      done  <= ((state == CHECK) && (state_n != POP)) || (state == FINISH);
      if (state == IDLE && sel) begin
        idx <= {pos_y, pos_x};
        nb  <= numero_bombas;
      end
      if (state == CHECK && !revealed[idx] && bomb_map[idx]) begin
        revealed  <= revealed | bomb_map;
        game_over <= 1'b1;
      end
      if (push) begin
        sp               <= sp + 7'd1;
        queued[push_val] <= 1'b1;
      end
      if (pop) begin
        sp            <= sp - 7'd1;
        cur           <= top;
        revealed[top] <= 1'b1;
        rev_cnt       <= rev_cnt + 7'd1;
        dir           <= 3'd0;
      end
      if (state == SCAN)  dir <= dir + 3'd1;
      if (state == FINISH && win_hit) win <= 1'b1;
    end
  end

endmodule

// File: tb/tb_revelar_celdas.sv
// Bench for revelar_celdas: directed scenarios plus random boards checked
// against a queue-based flood-fill model of the board.
module tb_revelar_celdas;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0;
  logic [2:0]   pos_x = '0, pos_y = '0;
  logic [63:0]  bomb_map = '0;
  logic [255:0] num_map = '0;
  logic [5:0]   numero_bombas = '0;
  logic [63:0]  revealed;
  logic         busy, done, game_over, win;

  int tests = 0;
  int fails = 0;

  logic [63:0] m_bomb;
  logic [63:0] m_rev;
  int          m_cnt [64];
  int          m_nb;
  bit          m_over, m_win;

  revelar_celdas dut (
    .clk(clk), .rst(rst), .sel(sel), .pos_x(pos_x), .pos_y(pos_y),
    .bomb_map(bomb_map), .num_map(num_map), .numero_bombas(numero_bombas),
    .revealed(revealed), .busy(busy), .done(done),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sel = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    m_rev = '0; m_over = 0; m_win = 0;
  endtask

  task automatic setup_board(input logic [63:0] m);
    m_bomb = m;
    m_nb   = $countones(m);
    for (int c = 0; c < 64; c++) begin
      int n;
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          int x, y;
          x = c % 8 + dx; y = c / 8 + dy;
          if ((dx != 0 || dy != 0) && x >= 0 && x < 8 && y >= 0 && y < 8 && m[y*8+x]) n++;
        end
      m_cnt[c] = n;
      num_map[c*4 +: 4] = 4'(n);
    end
    bomb_map      = m;
    numero_bombas = 6'(m_nb);
    do_reset();
  endtask

  // Expected outcome of one select; lat is the cycle in which done is seen.
  task automatic model_select(input int c0, output int lat);
    logic [63:0] seen;
    int q[$];
    int p;
    lat = 2;
    if (m_rev[c0]) return;
    if (m_bomb[c0]) begin
      m_rev  = m_rev | m_bomb;
      m_over = 1;
      return;
    end
    seen = '0; seen[c0] = 1'b1; q.push_back(c0); p = 0;
    while (q.size() > 0) begin
      int c;
      c = q.pop_back();
      m_rev[c] = 1'b1;
      if (m_cnt[c] == 0) begin
        p += 9;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int x, y, n;
            x = c % 8 + dx; y = c / 8 + dy; n = y*8 + x;
            if ((dx != 0 || dy != 0) && x >= 0 && x < 8 && y >= 0 && y < 8)
              if (!m_rev[n] && !seen[n] && !m_bomb[n]) begin
                seen[n] = 1'b1;
                q.push_back(n);
              end
          end
      end else p += 1;
    end
    lat = p + 3;
    if ($countones(m_rev & ~m_bomb) + m_nb == 64) m_win = 1;
  endtask

  task automatic do_select(input int x, input int y, input bit guard);
    int lat, cyc, busy_cyc, maxsp;
    bit got;
    model_select(y*8 + x, lat);
    @(negedge clk); pos_x = 3'(x); pos_y = 3'(y); sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    cyc = 1; busy_cyc = 0; maxsp = 0; got = 0;
    while (!got && cyc < 3000) begin
      if (busy) busy_cyc++;
      if (int'(dut.sp) > maxsp) maxsp = int'(dut.sp);
      if (done) got = 1;
      else begin
        if (guard && cyc == 3) begin pos_x = 3'd7; pos_y = 3'd7; sel = 1'b1; end
        else sel = 1'b0;
        @(negedge clk); cyc++;
      end
    end
    sel = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("done_cycle", 64'(cyc), 64'(lat));
    check("busy_cycles", 64'(busy_cyc), 64'(lat - 1));
    check("revealed", revealed, m_rev);
    check("game_over", 64'(game_over), 64'(m_over));
    check("win", 64'(win), 64'(m_win));
    check("busy_at_done", 64'(busy), 64'd0);
    check("stack_depth_ok", 64'(maxsp <= 64), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_ignored();
    bit act;
    act = 0;
    @(negedge clk); pos_x = 3'($urandom_range(7)); pos_y = 3'($urandom_range(7)); sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    repeat (12) begin
      if (busy || done) act = 1;
      @(negedge clk);
    end
    check("terminal_ignores_sel", 64'(act), 64'd0);
    check("terminal_revealed", revealed, m_rev);
    check("terminal_flags", {62'd0, game_over, win}, {62'd0, m_over, m_win});
  endtask

  initial begin
    logic [63:0] m;
    // Reset state
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    check("rst_revealed", revealed, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_win", 64'(win), 64'd0);

    // Non-zero cell (3,2) with count 2, then re-select it
    m = '0; m[10] = 1'b1; m[28] = 1'b1;
    setup_board(m);
    check("nz_count_19", 64'(num_map[19*4 +: 4]), 64'd2);
    do_select(3, 2, 0);
    check("nz_only_19", revealed, 64'h0000_0000_0008_0000);
    do_select(3, 2, 0);

    // Bomb select
    m = '0; m[0] = 1'b1; m[63] = 1'b1;
    setup_board(m);
    do_select(0, 0, 0);
    check("bomb_revealed", revealed, 64'h8000_0000_0000_0001);
    check_ignored();

    // Empty board: abort mid-fill with reset, then full fill
    setup_board(64'd0);
    @(negedge clk); pos_x = 3'd0; pos_y = 3'd0; sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    repeat (20) @(negedge clk);
    check("midfill_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_revealed", revealed, 64'd0);
    check("midrst_outputs", {60'd0, busy, done, game_over, win}, 64'd0);
    @(negedge clk); rst = 1'b0;
    do_select(0, 0, 0);
    check("empty_all_revealed", revealed, '1);
    check_ignored();

    // Bounded fill with a bomb at (7,7); stray sel mid-fill aims at the bomb
    m = '0; m[63] = 1'b1;
    setup_board(m);
    do_select(0, 0, 1);
    check("bounded_revealed", revealed, 64'h7FFF_FFFF_FFFF_FFFF);
    check("bounded_win", 64'(win), 64'd1);

    // Random boards
    for (int b = 0; b < 8; b++) begin
      m = '0;
      begin
        int k;
        k = $urandom_range(10, 1);
        while ($countones(m) < k) m[$urandom_range(63)] = 1'b1;
      end
      setup_board(m);
      for (int s = 0; s < 20 && !m_over && !m_win; s++)
        do_select($urandom_range(7), $urandom_range(7), 0);
      if (m_over || m_win) check_ignored();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
